// File: rtl/fht_stream_seq_if.sv
// Signal bundle between the FHT stream sequencer and its environment.
// It carries the ADC stream, the core bank buses and the result stream.
interface fht_stream_seq_if #(
    parameter int ADC_WIDTH = 16,
    parameter int D_BIT     = 24,
    parameter int A_BIT     = 8
);
    logic                 go;
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_valid;
    logic                 adc_ready;
    logic [3:0]           we;
    logic [A_BIT-1:0]     addr_wr;
    logic [D_BIT-1:0]     data;
    logic                 start;
    logic                 rdy;
    logic [A_BIT-1:0]     addr_rd;
    logic [D_BIT-1:0]     rd_data_0;
    logic [D_BIT-1:0]     rd_data_1;
    logic [D_BIT-1:0]     rd_data_2;
    logic [D_BIT-1:0]     rd_data_3;
    logic [D_BIT-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 err;

    modport slave (
        input  go, adc_data, adc_valid, rdy, rd_data_0, rd_data_1, rd_data_2, rd_data_3, out_ready,
        output adc_ready, we, addr_wr, data, start, addr_rd, out_data, out_valid, busy, err
    );

    modport master (
        output go, adc_data, adc_valid, rdy, rd_data_0, rd_data_1, rd_data_2, rd_data_3, out_ready,
        input  adc_ready, we, addr_wr, data, start, addr_rd, out_data, out_valid, busy, err
    );
endinterface

// File: rtl/fht_stream_seq.sv
// Load / start / readout sequencer around one FHT core: fills the four banks from the
// ADC stream, kicks the transform, then streams the result back in natural order.
module fht_stream_seq #(
    parameter int ADC_WIDTH = 16,
    parameter int D_BIT     = 24,
    parameter int A_BIT     = 8,
    parameter int RD_LAT    = 2,
    parameter int TIMEOUT   = 65535
) (
    input  logic            clk,
    input  logic            rst,
    fht_stream_seq_if.slave bus
);
    localparam int K_W   = A_BIT + 2;
    localparam int FRAC  = D_BIT - ADC_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_WAIT = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t           state_r, state_nx_s;
    logic [K_W-1:0]   k_r, k_nx_s;
    logic             last_wr_r, last_wr_nx_s;
    logic [TMO_W-1:0] tmo_r, tmo_nx_s;
    logic [LAT_W-1:0] lat_r, lat_nx_s;
    logic [A_BIT-1:0] row_r, row_nx_s;
    logic [1:0]       bank_r, bank_nx_s;
    logic [A_BIT-1:0] addr_rd_r, addr_rd_nx_s;
    logic [D_BIT-1:0] out_data_r, out_data_nx_s;
    logic             out_valid_r, out_valid_nx_s;
    logic             adc_ready_r, adc_ready_nx_s;
    logic [3:0]       we_r, we_nx_s;
    logic [A_BIT-1:0] addr_wr_r;
    logic [D_BIT-1:0] data_r;
    logic             start_r, busy_r, err_r, err_nx_s, rdy_r;
    logic             latch_s, xfer_s, accept_s, rise_s;
    logic [D_BIT-1:0] hold_1_r, hold_2_r, hold_3_r;

    // The core leaves its rows in bit-reversed order; reading row bit_rev(r) restores it.
    function automatic logic [A_BIT-1:0] bit_rev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        for (int i = 0; i < A_BIT; i++) begin
            r[i] = v[A_BIT-1-i];
        end
        return r;
    endfunction

    assign xfer_s   = (state_r == S_LOAD) && bus.adc_valid && adc_ready_r;
    assign accept_s = (state_r == S_DRAIN) && out_valid_r && bus.out_ready;
    assign rise_s   = bus.rdy && !rdy_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_nx_s     = state_r;
        k_nx_s         = k_r;
        last_wr_nx_s   = last_wr_r;
        tmo_nx_s       = tmo_r;
        lat_nx_s       = lat_r;
        row_nx_s       = row_r;
        bank_nx_s      = bank_r;
        addr_rd_nx_s   = addr_rd_r;
        out_data_nx_s  = out_data_r;
        out_valid_nx_s = out_valid_r;
        err_nx_s       = 1'b0;
        latch_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.go) begin
                    state_nx_s   = S_LOAD;
                    k_nx_s       = {K_W{1'b0}};
                    last_wr_nx_s = 1'b0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // Stay one extra cycle after the final transfer so START follows its write.
                if (last_wr_r) begin
                    state_nx_s   = S_START;
                    last_wr_nx_s = 1'b0;
                    tmo_nx_s     = {TMO_W{1'b0}};
                end else if (xfer_s) begin
                    k_nx_s       = k_r + K_W'(1);
                    last_wr_nx_s = (k_r == {K_W{1'b1}});
                end else begin
                    state_nx_s = S_LOAD;
                end
            end
            S_START: begin
                state_nx_s = S_WAIT;
                tmo_nx_s   = tmo_r + TMO_W'(1);
            end
            S_WAIT: begin
                if (rise_s) begin
                    state_nx_s   = S_RD_ADDR;
                    row_nx_s     = {A_BIT{1'b0}};
                    addr_rd_nx_s = {A_BIT{1'b0}};
                end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
                    state_nx_s = S_IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    tmo_nx_s = tmo_r + TMO_W'(1);
                end
            end
            S_RD_ADDR: begin
                state_nx_s = S_RD_WAIT;
                lat_nx_s   = LAT_W'(1);
            end
            S_RD_WAIT: begin
                if (lat_r == LAT_W'(RD_LAT)) begin
                    state_nx_s     = S_DRAIN;
                    latch_s        = 1'b1;
                    out_data_nx_s  = bus.rd_data_0;
                    out_valid_nx_s = 1'b1;
                    bank_nx_s      = 2'd0;
                end else begin
                    lat_nx_s = lat_r + LAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (accept_s && (bank_r == 2'd3)) begin
                    out_valid_nx_s = 1'b0;
                    bank_nx_s      = 2'd0;
                    if (row_r == {A_BIT{1'b1}}) begin
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s   = S_RD_ADDR;
                        row_nx_s     = row_r + A_BIT'(1);
                        addr_rd_nx_s = bit_rev(row_r + A_BIT'(1));
                    end
                end else if (accept_s) begin
                    bank_nx_s = bank_r + 2'd1;
                    case (bank_r)
                        2'd0:    out_data_nx_s = hold_1_r;
                        2'd1:    out_data_nx_s = hold_2_r;
                        default: out_data_nx_s = hold_3_r;
                    endcase
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end
            default: begin
                state_nx_s     = S_IDLE;
                out_valid_nx_s = 1'b0;
            end
        endcase
        adc_ready_nx_s = (state_nx_s == S_LOAD) && !last_wr_nx_s;
        if (xfer_s) begin
            we_nx_s = 4'b0001 << k_r[1:0];
        end else begin
            we_nx_s = 4'b0000;
        end
    end

    // Counters, bank write port, readout holding register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r         <= {K_W{1'b0}};
            last_wr_r   <= 1'b0;
            tmo_r       <= {TMO_W{1'b0}};
            lat_r       <= {LAT_W{1'b0}};
            row_r       <= {A_BIT{1'b0}};
            bank_r      <= 2'd0;
            addr_rd_r   <= {A_BIT{1'b0}};
            out_data_r  <= {D_BIT{1'b0}};
            out_valid_r <= 1'b0;
            adc_ready_r <= 1'b0;
            we_r        <= 4'b0000;
            addr_wr_r   <= {A_BIT{1'b0}};
            data_r      <= {D_BIT{1'b0}};
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            rdy_r       <= 1'b0;
            hold_1_r    <= {D_BIT{1'b0}};
            hold_2_r    <= {D_BIT{1'b0}};
            hold_3_r    <= {D_BIT{1'b0}};
        end else begin
            k_r         <= k_nx_s;
            last_wr_r   <= last_wr_nx_s;
            tmo_r       <= tmo_nx_s;
            lat_r       <= lat_nx_s;
            row_r       <= row_nx_s;
            bank_r      <= bank_nx_s;
            addr_rd_r   <= addr_rd_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
            adc_ready_r <= adc_ready_nx_s;
            we_r        <= we_nx_s;
            start_r     <= (state_nx_s == S_START);
            busy_r      <= (state_nx_s != S_IDLE);
            err_r       <= err_nx_s;
            rdy_r       <= bus.rdy;
            if (xfer_s) begin
                addr_wr_r <= k_r[K_W-1:2];
                data_r    <= {bus.adc_data, {FRAC{1'b0}}};
            end else begin
                addr_wr_r <= addr_wr_r;
                data_r    <= data_r;
            end
            if (latch_s) begin
                hold_1_r <= bus.rd_data_1;
                hold_2_r <= bus.rd_data_2;
                hold_3_r <= bus.rd_data_3;
            end else begin
                hold_1_r <= hold_1_r;
                hold_2_r <= hold_2_r;
                hold_3_r <= hold_3_r;
            end
        end
    end

    assign bus.adc_ready = adc_ready_r;
    assign bus.we        = we_r;
    assign bus.addr_wr   = addr_wr_r;
    assign bus.data      = data_r;
    assign bus.start     = start_r;
    assign bus.addr_rd   = addr_rd_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_fht_stream_seq.sv
// Directed bench for fht_stream_seq with a small bank-RAM core model whose transform
// leaves the data unchanged, so readout must reproduce the loaded image row-reordered.
module tb_fht_stream_seq;
    localparam int ADC_WIDTH = 16;
    localparam int D_BIT     = 24;
    localparam int A_BIT     = 3;
    localparam int RD_LAT    = 2;
    localparam int TIMEOUT   = 50;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fht_stream_seq_if #(.ADC_WIDTH(ADC_WIDTH), .D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

    fht_stream_seq #(
        .ADC_WIDTH(ADC_WIDTH), .D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core model: four banks, RD_LAT-stage registered read.
    logic [D_BIT-1:0] mem [4][8];
    logic [D_BIT-1:0] p1 [4];
    logic [D_BIT-1:0] p2 [4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.we[b]) mem[b][bus.addr_wr] <= bus.data;
            p1[b] <= mem[b][bus.addr_rd];
            p2[b] <= p1[b];
        end
    end
    assign bus.rd_data_0 = p2[0];
    assign bus.rd_data_1 = p2[1];
    assign bus.rd_data_2 = p2[2];
    assign bus.rd_data_3 = p2[3];

    int row_seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic logic [15:0] samp(input int k);
        return 16'hA500 + 16'(k * 37);
    endfunction

    function automatic logic [23:0] expw(input int n);
        int k;
        k = 4 * row_seq[n / 4] + (n % 4);
        return {samp(k), 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input int k);
        logic [3:0] oh;
        oh = 4'b0001 << (k % 4);
        chk("we", 32'(bus.we), 32'(oh));
        chk("addr_wr", 32'(bus.addr_wr), 32'(k / 4));
        chk("wdata", 32'(bus.data), 32'({samp(k), 8'h00}));
    endtask

    task automatic readout(input bit rnd, input int exp_gap);
        int n, cyc, gap;
        bit acc, vld;
        logic [D_BIT-1:0] d;
        logic [A_BIT-1:0] a;
        n = 0; cyc = 0; gap = 0;
        while (n < 32 && cyc < 1000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vld = bus.out_valid;
            acc = vld && bus.out_ready;
            d   = bus.out_data;
            a   = bus.addr_rd;
            if (n > 0 && !vld) gap++;
            @(negedge clk);
            cyc++;
            if (acc) begin
                chk("out_word", 32'(d), 32'(expw(n)));
                if (n % 4 == 0) chk("addr_rd", 32'(a), 32'(row_seq[n / 4]));
                n++;
            end else if (vld) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(d));
            end
        end
        chk("word_count", 32'(n), 32'd32);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("valid_done", 32'(bus.out_valid), 32'd0);
        if (exp_gap >= 0) chk("row_gap", 32'(gap), 32'(exp_gap));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int k, cyc;
        bit prev, v;
        rst = 1'b1;
        bus.go = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = 16'h0000;
        bus.rdy = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.adc_ready), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_addr_rd", 32'(bus.addr_rd), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a load after five samples.
        bus.go = 1'b1; @(negedge clk); bus.go = 1'b0;
        chk("busy_after_go", 32'(bus.busy), 32'd1);
        for (k = 0; k < 5; k++) begin
            bus.adc_valid = 1'b1; bus.adc_data = samp(100 + k);
            @(negedge clk);
        end
        chk("we_k4", 32'(bus.we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ready", 32'(bus.adc_ready), 32'd0);
        chk("midrst_we", 32'(bus.we), 32'd0);
        chk("midrst_addr_wr", 32'(bus.addr_wr), 32'd0);
        bus.adc_valid = 1'b0;
        bus.go = 1'b1;
        @(negedge clk);
        chk("go_with_rst", 32'(bus.busy), 32'd0);
        bus.go = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(bus.busy), 32'd0);

        // Full-rate load, iRDY held high across START.
        bus.rdy = 1'b1;
        bus.go = 1'b1; @(negedge clk); bus.go = 1'b0;
        for (k = 0; k < 32; k++) begin
            chk("adc_ready", 32'(bus.adc_ready), 32'd1);
            bus.adc_valid = 1'b1; bus.adc_data = samp(k);
            @(negedge clk);
            chk_write(k);
        end
        bus.adc_valid = 1'b0;
        chk("ready_after_last", 32'(bus.adc_ready), 32'd0);
        chk("start_early", 32'(bus.start), 32'd0);
        @(negedge clk);
        chk("start", 32'(bus.start), 32'd1);
        chk("we_at_start", 32'(bus.we), 32'd0);
        @(negedge clk);
        chk("start_once", 32'(bus.start), 32'd0);
        repeat (2) @(negedge clk);
        bus.rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("wait_no_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("wait_busy", 32'(bus.busy), 32'd1);
        bus.rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("valid_latency", 32'(bus.out_valid), 32'd0);
        readout(1'b0, 21);

        // Load with random valid gaps, then readout with random backpressure.
        bus.go = 1'b1; @(negedge clk); bus.go = 1'b0;
        k = 0; prev = 1'b0; cyc = 0;
        while (k < 32 && cyc < 500) begin
            if (prev) chk_write(k - 1);
            else chk("we_gap", 32'(bus.we), 32'd0);
            v = ($urandom_range(0, 2) != 0);
            bus.adc_valid = v; bus.adc_data = samp(k);
            prev = v && bus.adc_ready;
            if (prev) k++;
            @(negedge clk);
            cyc++;
        end
        bus.adc_valid = 1'b0;
        chk("gap_load_count", 32'(k), 32'd32);
        if (prev) chk_write(k - 1);
        @(negedge clk);
        chk("start_gap", 32'(bus.start), 32'd1);
        repeat (2) @(negedge clk);
        bus.rdy = 1'b0;
        repeat (5) @(negedge clk);
        bus.rdy = 1'b1;
        repeat (3) @(negedge clk);
        readout(1'b1, -1);

        // iRDY never rises: timeout.
        bus.rdy = 1'b0;
        bus.go = 1'b1; @(negedge clk); bus.go = 1'b0;
        bus.adc_valid = 1'b1;
        for (k = 0; k < 32; k++) begin
            bus.adc_data = samp(k);
            @(negedge clk);
        end
        bus.adc_valid = 1'b0;
        @(negedge clk);
        chk("start_t6", 32'(bus.start), 32'd1);
        for (int j = 1; j < TIMEOUT; j++) begin
            bus.go = (j == 10);
            @(negedge clk);
            chk("no_err_early", 32'(bus.err), 32'd0);
            chk("t6_no_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.go = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_idle", 32'(bus.busy), 32'd0);
        chk("err_no_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(bus.err), 32'd0);
        chk("idle_stays", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
